// File: rtl/multiport_mem_pkg.sv
// Shared types and helpers for the multi-port memory.
// Holds the sequencer state enum and the address-width derivation.
package multiport_mem_pkg;

    // Sequencer states: clearing the array, then normal operation
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Address width: ceil(log2(depth)), never narrower than one bit
    function automatic int calc_aw(input int depth);
        int aw;
        aw = $clog2(depth);
        if (aw < 1) begin
            aw = 1;
        end
        return aw;
    endfunction

endpackage

// File: rtl/mem_read_port.sv
// One registered read port of the multi-port memory.
// Does the address range check, write bypass and output registers.
module mem_read_port
    import multiport_mem_pkg::*;
#(
    parameter int W      = 4,
    parameter int DEPTH  = 16,
    parameter int AW     = calc_aw(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] raddr,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [W-1:0]  mem [DEPTH],
    output logic [W-1:0]  rdata,
    output logic          rvalid
);

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic          in_range;
    logic          hit;
    logic [W-1:0]  word;
    logic [W-1:0]  rdata_d;
    logic [W-1:0]  rdata_q;
    logic          rvalid_d;
    logic          rvalid_q;

    // Select the word to return: zero when out of range, new data on a hit
    always_comb begin
        in_range = ({1'b0, raddr} < DEPTH_X);
        hit      = wen && (waddr == raddr);
        word     = '0;
        if (in_range) begin
            word = mem[raddr];
            if ((BYPASS != 0) && hit) begin
                word = wdata;
            end
        end
    end

    // Capture on enable, otherwise hold the last data and drop valid
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = en;
        if (en) begin
            rdata_d = word;
        end
    end

    // Output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: rtl/multiport_mem.sv
// Single-write, multi-read memory that clears itself after reset.
// Accesses are accepted only once the zero sweep has finished.
module multiport_mem
    import multiport_mem_pkg::*;
#(
    parameter int W      = 4,
    parameter int DEPTH  = 16,
    parameter int NR     = 2,
    parameter int BYPASS = 1,
    parameter int AW     = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_wen,
    input  logic [AW-1:0]    IN_waddr,
    input  logic [W-1:0]     IN_wdata,
    input  logic [NR-1:0]    IN_ren,
    input  logic [NR*AW-1:0] IN_raddr,
    output logic [NR*W-1:0]  OUT_rdata,
    output logic [NR-1:0]    OUT_rvalid,
    output logic             OUT_ready
);

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);

    state_e          state_d;
    state_e          state_q;
    logic [AW-1:0]   cnt_d;
    logic [AW-1:0]   cnt_q;
    logic            ready_d;
    logic            ready_q;

    logic            run;
    logic            uwen;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [W-1:0]    mem_wd;
    logic [W-1:0]    mem_q [DEPTH];

    // Sweep sequencer: step through every address, then enter RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; ready is a flop so it rises on the first RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // User write is live only in RUN and only for in-range addresses
    always_comb begin
        run  = (state_q == RUN);
        uwen = run && IN_wen && ({1'b0, IN_waddr} < DEPTH_X);
    end

    // Array write mux: sweep zeros during INIT, user data during RUN
    always_comb begin
        mem_we = uwen;
        mem_wa = IN_waddr;
        mem_wd = IN_wdata;
        if (!run) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
        end
    end

    // Storage array; left untouched while reset is held
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rp
        mem_read_port #(
            .W      (W),
            .DEPTH  (DEPTH),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rp (
            .clk    (clk),
            .rst    (rst),
            .en     (IN_ren[i] && run),
            .raddr  (IN_raddr[i*AW +: AW]),
            .wen    (uwen),
            .waddr  (IN_waddr),
            .wdata  (IN_wdata),
            .mem    (mem_q),
            .rdata  (OUT_rdata[i*W +: W]),
            .rvalid (OUT_rvalid[i])
        );
    end

    assign OUT_ready = ready_q;

endmodule

// File: doc/multiport_mem.md
MULTIPORT_MEM -- requirements
Module: multiport_mem

Interface
REQ-001 Parameter W, default 4, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of words (>=2; need not be a power of two).
REQ-003 Parameter NR, default 2, number of independent read ports (>=1).
REQ-004 Parameter BYPASS, default 1; 1 = write-first read-during-write, 0 = read-first.
REQ-005 Derived constant AW = max(1, clog2(DEPTH)), address width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 IN_wen  input  1  write enable.
REQ-009 IN_waddr  input  AW  write address.
REQ-010 IN_wdata  input  W  write data.
REQ-011 IN_ren  input  NR  per-port read enable.
REQ-012 IN_raddr  input  NR x AW  per-port read address, port i in slice i.
REQ-013 OUT_rdata  output  NR x W  per-port registered read data.
REQ-014 OUT_rvalid  output  NR  per-port read-data-valid strobe.
REQ-015 OUT_ready  output  1  high when the array is initialised and accepting accesses.

Function
REQ-016 FSM states INIT and RUN; INIT is entered on reset, RUN when the clear sweep completes.
REQ-017 INIT: internal counter writes zero to address 0, 1, ... DEPTH-1, one word per cycle; transition to RUN in the cycle after address DEPTH-1 is written (exactly DEPTH cycles after rst deasserts).
REQ-018 OUT_ready = 1 only in RUN; registered, rises on the first RUN cycle.
REQ-019 In INIT, IN_wen and IN_ren are ignored: no user write occurs, OUT_rvalid stays 0, OUT_rdata holds 0.
REQ-020 RUN write: IN_wen=1 with IN_waddr<DEPTH stores IN_wdata at the next edge; IN_waddr>=DEPTH drops the write silently.
REQ-021 RUN read: IN_ren[i]=1 at edge k gives OUT_rdata[i] and OUT_rvalid[i]=1 after edge k (latency 1).
REQ-022 IN_ren[i]=0: OUT_rvalid[i]=0 next cycle; OUT_rdata[i] holds its previous value.
REQ-023 Read of IN_raddr[i]>=DEPTH returns all-zero data with OUT_rvalid[i]=1.
REQ-024 Read and write to the same address in the same cycle: BYPASS=1 returns IN_wdata; BYPASS=0 returns the prior stored word; the write completes in both cases.
REQ-025 Multiple ports reading the same address in one cycle all return identical data; ports are fully independent, no arbitration or stall.
REQ-026 Zero-extension/truncation is never applied: data paths are exactly W bits.

Reset
REQ-027 rst=1 at an edge: FSM to INIT, sweep counter to 0, OUT_ready=0, OUT_rvalid=0, OUT_rdata=0.
REQ-028 rst asserted mid-sweep or in RUN restarts the sweep from address 0; the array content is zero in full once RUN is reached again.
REQ-029 While rst=1 the array is not written.

Structure
REQ-030 Package multiport_mem_pkg holds the state enum (INIT, RUN) and the AW derivation function.
REQ-031 One sub-module, mem_read_port, instantiated NR times: address range check, bypass compare, output registers for one port.
REQ-032 Storage is a single unpacked array of DEPTH words of W bits, written from one always_ff.

Verification (W=4, DEPTH=16, NR=2, BYPASS=1 unless stated)
REQ-033 Release rst at cycle 0 -> OUT_ready=0 for cycles 0-15, 1 from cycle 16; reads of all 16 addresses return 0.
REQ-034 Write 0xA to addr 3, then ren[0]=1 raddr[0]=3 and ren[1]=1 raddr[1]=3 -> both OUT_rdata=0xA, OUT_rvalid=2'b11 one cycle later.
REQ-035 Same cycle wen=1 waddr=5 wdata=0x7 (addr 5 holds 0x2), ren[0] raddr=5 -> 0x7 with BYPASS=1; 0x2 with BYPASS=0; next read returns 0x7.
REQ-036 DEPTH=12: write 0xF to addr 13 -> dropped, all reads unchanged; read addr 14 -> 0x0, rvalid=1.
REQ-037 Pulse rst at sweep address 7 after addr 2 held 0x9 -> OUT_ready low for 16 further cycles; addr 2 reads 0x0 afterwards.
REQ-038 ren[1]=0 after a read of 0xA -> OUT_rvalid[1]=0, OUT_rdata[1] stays 0xA.
